game_sequencer: RTL and testbench

Top-level game flow controller for the VGA space-invaders design. It sequences attract, level start, play, pause, level-clear ascent and game-over. It also schedules alien formation moves from a per-frame tick and arbitrates fire requests against the single bullet. All outputs are strobes and levels consumed by the sprite/position datapath and the pixel renderer; the block itself holds no positions.

---
 rtl/game_seq_if.sv | 37 +++
 rtl/game_sequencer.sv | 179 +++++++++++++++++
 tb/tb_game_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_seq_if.sv
// game_seq_if: control bundle between the game-flow sequencer and the
// sprite/position datapath plus renderer.
//   master : datapath side - drives frame tick, buttons and game status flags,
//            consumes state, level and the action strobes.
//   slave  : sequencer side - the mirror image.
interface game_seq_if;
    logic       frame_tick;
    logic       btn_fire;
    logic       btn_pause;
    logic       bullet_active;
    logic       all_dead;
    logic       alien_hit_player;
    logic       player_at_top;
    logic [2:0] state;
    logic       load_level;
    logic       alien_step;
    logic       alien_down;
    logic       alien_dir;
    logic       fire_grant;
    logic       player_ascend;
    logic [2:0] level;
    logic       game_over;

    modport master (
        output frame_tick, btn_fire, btn_pause, bullet_active, all_dead,
               alien_hit_player, player_at_top,
        input  state, load_level, alien_step, alien_down, alien_dir,
               fire_grant, player_ascend, level, game_over
    );

    modport slave (
        input  frame_tick, btn_fire, btn_pause, bullet_active, all_dead,
               alien_hit_player, player_at_top,
        output state, load_level, alien_step, alien_down, alien_dir,
               fire_grant, player_ascend, level, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// game_sequencer: game flow controller for the space-invaders design.
// Sequences attract, level start, play, pause, level-clear ascent and game
// over; schedules formation moves from the frame tick and grants fire
// requests against the single bullet. Holds no positions itself.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - game_seq_if.slave: frame tick, buttons, status flags in;
//          state, level, game_over levels and action strobes out.
// Every output is a register; strobes appear the cycle after their cause.
module game_sequencer #(
    parameter int INIT_PERIOD   = 6,
    parameter int MIN_PERIOD    = 1,
    parameter int STEPS_PER_ROW = 144,
    parameter int MAX_LEVEL     = 7,
    parameter int OVER_HOLD     = 60
) (
    input  logic        clk,
    input  logic        rst,
    game_seq_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEVEL_INIT = 3'd1,
        S_PLAY       = 3'd2,
        S_PAUSE      = 3'd3,
        S_WIN_ASCEND = 3'd4,
        S_GAMEOVER   = 3'd5
    } state_t;

    localparam logic [7:0] STEP_LAST = 8'(STEPS_PER_ROW - 1);
    localparam logic [7:0] HOLD_MAX  = 8'(OVER_HOLD);
    localparam logic [2:0] LVL_MAX   = 3'(MAX_LEVEL);
    localparam logic [3:0] PER_INIT  = 4'(INIT_PERIOD);
    localparam logic [3:0] PER_MIN   = 4'(MIN_PERIOD);

    state_t     state_q, state_d;
    logic [2:0] level_q, level_d;
    logic       dir_q, dir_d;
    logic [3:0] frame_q, frame_d;
    logic [7:0] step_q, step_d;
    logic [7:0] hold_q, hold_d;
    logic       fire_prev_q, pause_prev_q;
    logic       load_q, load_d;
    logic       astep_q, astep_d;
    logic       adown_q, adown_d;
    logic       grant_q, grant_d;
    logic       asc_q, asc_d;
    logic       go_q;

    logic       fire_edge, pause_edge;
    logic [3:0] per_shift, period, period_last;

    assign fire_edge  = bus.btn_fire  & ~fire_prev_q;
    assign pause_edge = bus.btn_pause & ~pause_prev_q;

    // Step period halves per level; deep levels shift to zero, so clamp.
    assign per_shift   = PER_INIT >> level_q;
    assign period      = (per_shift < PER_MIN) ? PER_MIN : per_shift;
    assign period_last = period - 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            level_q      <= '0;
            dir_q        <= 1'b1;
            frame_q      <= '0;
            step_q       <= '0;
            hold_q       <= '0;
            fire_prev_q  <= 1'b0;
            pause_prev_q <= 1'b0;
            load_q       <= 1'b0;
            astep_q      <= 1'b0;
            adown_q      <= 1'b0;
            grant_q      <= 1'b0;
            asc_q        <= 1'b0;
            go_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            dir_q        <= dir_d;
            frame_q      <= frame_d;
            step_q       <= step_d;
            hold_q       <= hold_d;
            fire_prev_q  <= bus.btn_fire;
            pause_prev_q <= bus.btn_pause;
            load_q       <= load_d;
            astep_q      <= astep_d;
            adown_q      <= adown_d;
            grant_q      <= grant_d;
            asc_q        <= asc_d;
            // Registered from next state so it stays aligned with bus.state.
            go_q         <= (state_d == S_GAMEOVER);
        end
    end

    // Strobes depend only on the current state, so an action decoded in the
    // same cycle as a state change still fires.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        dir_d   = dir_q;
        frame_d = frame_q;
        step_d  = step_q;
        hold_d  = hold_q;
        load_d  = 1'b0;
        astep_d = 1'b0;
        adown_d = 1'b0;
        grant_d = 1'b0;
        asc_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fire_edge) begin
                    state_d = S_LEVEL_INIT;
                    level_d = '0;
                end
            end
            S_LEVEL_INIT: begin
                load_d  = 1'b1;
                frame_d = '0;
                step_d  = '0;
                dir_d   = 1'b1;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    if (frame_q == period_last) begin
                        frame_d = '0;
                        if (step_q < STEP_LAST) begin
                            astep_d = 1'b1;
                            step_d  = step_q + 8'd1;
                        end else begin
                            adown_d = 1'b1;
                            dir_d   = ~dir_q;
                            step_d  = '0;
                        end
                    end else begin
                        frame_d = frame_q + 4'd1;
                    end
                end
                // A press while the bullet flies is simply lost.
                if (fire_edge && !bus.bullet_active) grant_d = 1'b1;
                if (bus.alien_hit_player)  state_d = S_GAMEOVER;
                else if (bus.all_dead)     state_d = S_WIN_ASCEND;
                else if (pause_edge)       state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (pause_edge) state_d = S_PLAY;
            end
            S_WIN_ASCEND: begin
                if (bus.frame_tick) asc_d = 1'b1;
                if (bus.player_at_top) begin
                    level_d = (level_q == LVL_MAX) ? level_q : level_q + 3'd1;
                    state_d = S_LEVEL_INIT;
                end
            end
            S_GAMEOVER: begin
                if (bus.frame_tick && hold_q != HOLD_MAX) hold_d = hold_q + 8'd1;
                // Restart only once the hold has fully elapsed (old value).
                if (fire_edge && hold_q == HOLD_MAX) begin
                    state_d = S_LEVEL_INIT;
                    level_d = '0;
                    hold_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.state         = state_q;
    assign bus.level         = level_q;
    assign bus.alien_dir     = dir_q;
    assign bus.load_level    = load_q;
    assign bus.alien_step    = astep_q;
    assign bus.alien_down    = adown_q;
    assign bus.fire_grant    = grant_q;
    assign bus.player_ascend = asc_q;
    assign bus.game_over     = go_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed walk through the game flow followed by a
// randomized phase, all outputs compared every cycle against a reference
// model built from the game rules, plus pulse-count checks on scenarios.
module tb_game_sequencer;
    localparam int INIT_P = 6, MIN_P = 1, ROW = 144, MAXL = 7, HOLD = 60;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    game_seq_if bus ();
    game_sequencer #(
        .INIT_PERIOD(INIT_P), .MIN_PERIOD(MIN_P), .STEPS_PER_ROW(ROW),
        .MAX_LEVEL(MAXL), .OVER_HOLD(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: game mode as a plain integer, counters as integers.
    int m_mode, m_lvl, m_dir, m_frames, m_steps, m_hold;
    int m_fprev, m_pprev;
    int m_load, m_astep, m_adown, m_grant, m_asc;

    // Pulse counters observed on the DUT for scenario checks.
    int c_load, c_step, c_down, c_grant, c_asc;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_lvl = 0; m_dir = 1; m_frames = 0; m_steps = 0; m_hold = 0;
        m_fprev = 0; m_pprev = 0;
        m_load = 0; m_astep = 0; m_adown = 0; m_grant = 0; m_asc = 0;
    endtask

    // One clock of game rules, given the inputs presently on the bus.
    task automatic model_step();
        int fe, pe, per, nxt;
        fe = (bus.btn_fire && !m_fprev) ? 1 : 0;
        pe = (bus.btn_pause && !m_pprev) ? 1 : 0;
        m_fprev = int'(bus.btn_fire);
        m_pprev = int'(bus.btn_pause);
        m_load = 0; m_astep = 0; m_adown = 0; m_grant = 0; m_asc = 0;
        nxt = m_mode;
        if (m_mode == 0) begin
            if (fe == 1) begin nxt = 1; m_lvl = 0; end
        end else if (m_mode == 1) begin
            m_load = 1; m_frames = 0; m_steps = 0; m_dir = 1; nxt = 2;
        end else if (m_mode == 2) begin
            if (bus.frame_tick) begin
                per = INIT_P / (1 << m_lvl);
                if (per < MIN_P) per = MIN_P;
                if (m_frames == per - 1) begin
                    m_frames = 0;
                    if (m_steps < ROW - 1) begin m_astep = 1; m_steps++; end
                    else begin m_adown = 1; m_dir = 1 - m_dir; m_steps = 0; end
                end else m_frames++;
            end
            if (fe == 1 && !bus.bullet_active) m_grant = 1;
            if (bus.alien_hit_player) nxt = 5;
            else if (bus.all_dead) nxt = 4;
            else if (pe == 1) nxt = 3;
        end else if (m_mode == 3) begin
            if (pe == 1) nxt = 2;
        end else if (m_mode == 4) begin
            if (bus.frame_tick) m_asc = 1;
            if (bus.player_at_top) begin
                m_lvl = (m_lvl + 1 > MAXL) ? MAXL : m_lvl + 1;
                nxt = 1;
            end
        end else begin
            if (fe == 1 && m_hold == HOLD) begin nxt = 1; m_lvl = 0; m_hold = 0; end
            else if (bus.frame_tick && m_hold < HOLD) m_hold++;
        end
        m_mode = nxt;
    endtask

    // Advance one clock with the inputs currently driven, then compare.
    task automatic cyc();
        if (rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
        check("state",  {5'd0, bus.state},          8'(m_mode));
        check("level",  {5'd0, bus.level},          8'(m_lvl));
        check("dir",    {7'd0, bus.alien_dir},      8'(m_dir));
        check("gover",  {7'd0, bus.game_over},      8'(m_mode == 5));
        check("load",   {7'd0, bus.load_level},     8'(m_load));
        check("step",   {7'd0, bus.alien_step},     8'(m_astep));
        check("down",   {7'd0, bus.alien_down},     8'(m_adown));
        check("grant",  {7'd0, bus.fire_grant},     8'(m_grant));
        check("ascend", {7'd0, bus.player_ascend},  8'(m_asc));
        c_load  += int'(bus.load_level);
        c_step  += int'(bus.alien_step);
        c_down  += int'(bus.alien_down);
        c_grant += int'(bus.fire_grant);
        c_asc   += int'(bus.player_ascend);
    endtask

    task automatic clr();
        c_load = 0; c_step = 0; c_down = 0; c_grant = 0; c_asc = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1; cyc();
            bus.frame_tick = 1'b0; cyc();
        end
    endtask

    task automatic press_fire();
        bus.btn_fire = 1'b1; cyc();
        bus.btn_fire = 1'b0; cyc();
    endtask

    task automatic press_pause();
        bus.btn_pause = 1'b1; cyc();
        bus.btn_pause = 1'b0; cyc();
    endtask

    task automatic win();
        bus.all_dead = 1'b1; cyc();
        bus.all_dead = 1'b0; cyc();
        bus.player_at_top = 1'b1; cyc();
        bus.player_at_top = 1'b0; cyc(); cyc();
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_tick = 1'b0; bus.btn_fire = 1'b0; bus.btn_pause = 1'b0;
        bus.bullet_active = 1'b0; bus.all_dead = 1'b0;
        bus.alien_hit_player = 1'b0; bus.player_at_top = 1'b0;
        model_reset(); clr();
        cyc(); cyc();
        check("rst_state", {5'd0, bus.state}, 8'd0);
        check("rst_dir",   {7'd0, bus.alien_dir}, 8'd1);
        rst = 1'b0;
        cyc();

        // Start: IDLE -> LEVEL_INIT -> PLAY with one load pulse.
        clr();
        press_fire();
        cyc(); cyc();
        check("start_state", {5'd0, bus.state}, 8'd2);
        check("load_once",   8'(c_load), 8'd1);

        // Level 0: steps every 6 ticks; row end after 144 step points.
        clr();
        ticks(12);
        check("l0_steps12", 8'(c_step), 8'd2);
        ticks(ROW * INIT_P - 12);
        check("row_steps", 8'(c_step), 8'd143);
        check("row_down",  8'(c_down), 8'd1);
        check("row_dir",   {7'd0, bus.alien_dir}, 8'd0);

        // Fire arbitration.
        clr();
        press_fire();
        check("grant_free", 8'(c_grant), 8'd1);
        clr();
        bus.bullet_active = 1'b1; press_fire(); bus.bullet_active = 1'b0; cyc();
        check("grant_busy", 8'(c_grant), 8'd0);
        clr();
        bus.btn_fire = 1'b1;
        for (int i = 0; i < 100; i++) cyc();
        bus.btn_fire = 1'b0; cyc();
        check("grant_hold", 8'(c_grant), 8'd1);

        // Pause freezes everything, resume continues.
        ticks(2);
        press_pause();
        check("pause_state", {5'd0, bus.state}, 8'd3);
        clr();
        ticks(20);
        press_fire();
        check("pause_quiet", 8'(c_step + c_down + c_grant + c_asc), 8'd0);
        press_pause();
        check("resume_state", {5'd0, bus.state}, 8'd2);
        ticks(7);

        // Level clear, ascent, level 1 with period 3.
        bus.all_dead = 1'b1; cyc(); bus.all_dead = 1'b0; cyc();
        check("win_state", {5'd0, bus.state}, 8'd4);
        clr();
        ticks(3);
        check("ascend3", 8'(c_asc), 8'd3);
        bus.player_at_top = 1'b1; cyc(); bus.player_at_top = 1'b0; cyc(); cyc();
        check("lvl1", {5'd0, bus.level}, 8'd1);
        clr();
        ticks(6);
        check("l1_steps", 8'(c_step), 8'd2);

        // Climb to the level cap and past it.
        for (int i = 0; i < 7; i++) win();
        check("lvl_sat", {5'd0, bus.level}, 8'd7);
        clr();
        ticks(4);
        check("l7_steps", 8'(c_step), 8'd4);

        // Hit together with all_dead: game over wins.
        bus.alien_hit_player = 1'b1; bus.all_dead = 1'b1; cyc();
        bus.alien_hit_player = 1'b0; bus.all_dead = 1'b0; cyc();
        check("go_state", {5'd0, bus.state}, 8'd5);
        check("go_flag",  {7'd0, bus.game_over}, 8'd1);
        ticks(30);
        press_fire();
        check("go_early", {5'd0, bus.state}, 8'd5);
        ticks(30);
        press_fire();
        cyc();
        check("go_restart", {5'd0, bus.state}, 8'd2);
        check("go_lvl0",    {5'd0, bus.level}, 8'd0);

        // Randomized phase with occasional mid-operation resets.
        for (int i = 0; i < 6000; i++) begin
            rst                  = ($urandom_range(0, 399) == 0);
            bus.frame_tick       = ($urandom_range(0, 2) == 0);
            bus.btn_fire         = ($urandom_range(0, 3) == 0);
            bus.btn_pause        = ($urandom_range(0, 29) == 0);
            bus.bullet_active    = ($urandom_range(0, 1) == 0);
            bus.all_dead         = ($urandom_range(0, 149) == 0);
            bus.alien_hit_player = ($urandom_range(0, 249) == 0);
            bus.player_at_top    = ($urandom_range(0, 19) == 0);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
